// File: rtl/fcb_config_sequencer.sv
// Wishbone master that loads one bitstream into the eFPGA configuration block:
// programs length/control, streams words from a valid/ready source, polls status.
module fcb_config_sequencer #(
  parameter int SHIFT_WAIT   = 40,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] len_bits,
  input  logic [31:0] src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic [2:0]  wb_address,
  output logic [31:0] wb_data_out,
  input  logic [31:0] wb_data_in,
  output logic [3:0]  wb_select,
  output logic        wb_stb,
  output logic        wb_we,
  output logic        wb_bus_cycle,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] words_sent
);

  typedef enum logic [2:0] {
    IDLE, WR_LEN, WR_CTRL, WAIT_SRC, WR_WORD, SHIFT, POLL, CLR_CTRL
  } state_t;

  state_t      state, state_next;
  logic [31:0] nwords, wait_cnt, timeout_cnt;
  logic        n_stb, n_we;
  logic [2:0]  n_addr;
  logic [31:0] n_data;
  logic        ok_to_clr, fail_to_clr, start_ok, start_zero, poll_wait;
  logic [32:0] len_sum;
  logic        unused_ok;

  assign len_sum      = {1'b0, len_bits} + 33'd31;
  assign wb_select    = wb_stb ? 4'hF : 4'h0;
  assign wb_bus_cycle = wb_stb;
  assign unused_ok    = ^{wb_data_in[31:2], wb_data_in[0], len_sum[4:0]};

  // Source handshake: a word transfers in the cycle where src_valid and
  // src_ready are both high; src_ready is only raised when src_valid is seen.
  // Bus outputs are registered, so the comb block computes the access that
  // will be on the bus while the FSM sits in state_next.
  always_comb begin
    state_next  = state;
    n_stb       = 1'b0;
    n_we        = 1'b0;
    n_addr      = 3'd0;
    n_data      = 32'h0;
    src_ready   = 1'b0;
    ok_to_clr   = 1'b0;
    fail_to_clr = 1'b0;
    start_ok    = 1'b0;
    start_zero  = 1'b0;
    poll_wait   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_bits != 32'h0) begin
            start_ok   = 1'b1;
            state_next = WR_LEN;
            n_stb      = 1'b1;
            n_we       = 1'b1;
            n_addr     = 3'd2;
            n_data     = len_bits;
          end else begin
            start_zero = 1'b1;
          end
        end
      end
      WR_LEN: begin
        state_next = WR_CTRL;
        n_stb      = 1'b1;
        n_we       = 1'b1;
        n_addr     = 3'd0;
        n_data     = 32'h1;
      end
      WR_CTRL: state_next = WAIT_SRC;
      WAIT_SRC: begin
        if (src_valid) begin
          src_ready  = 1'b1;
          state_next = WR_WORD;
          n_stb      = 1'b1;
          n_we       = 1'b1;
          n_addr     = 3'd1;
          n_data     = src_data;
        end
      end
      WR_WORD: state_next = SHIFT;
      SHIFT: begin
        if (wait_cnt <= 32'd1) begin
          state_next = POLL;
          n_stb      = 1'b1;
          n_addr     = 3'd4;
        end
      end
      POLL: begin
        if (wb_data_in[1]) begin
          ok_to_clr  = 1'b1;
          state_next = CLR_CTRL;
          n_stb      = 1'b1;
          n_we       = 1'b1;
        end else if (words_sent < nwords) begin
          state_next = WAIT_SRC;
        end else if (timeout_cnt >= 32'(DONE_TIMEOUT - 1)) begin
          fail_to_clr = 1'b1;
          state_next  = CLR_CTRL;
          n_stb       = 1'b1;
          n_we        = 1'b1;
        end else begin
          poll_wait = 1'b1;
          n_stb     = 1'b1;
          n_addr    = 3'd4;
        end
      end
      CLR_CTRL: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    // Abort overrides everything, including a completion seen in POLL.
    if (abort && state != IDLE && state != CLR_CTRL) begin
      state_next  = CLR_CTRL;
      src_ready   = 1'b0;
      ok_to_clr   = 1'b0;
      fail_to_clr = 1'b1;
      poll_wait   = 1'b0;
      n_stb       = 1'b1;
      n_we        = 1'b1;
      n_addr      = 3'd0;
      n_data      = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wb_stb      <= 1'b0;
      wb_we       <= 1'b0;
      wb_address  <= 3'd0;
      wb_data_out <= 32'h0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      words_sent  <= 32'h0;
      nwords      <= 32'h0;
      wait_cnt    <= 32'h0;
      timeout_cnt <= 32'h0;
    end else begin
      state       <= state_next;
      wb_stb      <= n_stb;
      wb_we       <= n_we;
      wb_address  <= n_addr;
      wb_data_out <= n_data;
      busy        <= (state_next != IDLE) && (state_next != CLR_CTRL);
      done        <= ok_to_clr;
      if (start_ok) begin
        error       <= 1'b0;
        words_sent  <= 32'h0;
        nwords      <= {5'd0, len_sum[32:5]};
        timeout_cnt <= 32'h0;
      end
      if (start_zero || fail_to_clr) error <= 1'b1;
      if (state == WR_WORD && words_sent < nwords) words_sent <= words_sent + 32'd1;
      if (state == WR_WORD) wait_cnt <= 32'(SHIFT_WAIT);
      else if (state == SHIFT && wait_cnt != 32'h0) wait_cnt <= wait_cnt - 32'd1;
      if (poll_wait && timeout_cnt < 32'(DONE_TIMEOUT)) timeout_cnt <= timeout_cnt + 32'd1;
    end
  end

endmodule

// File: doc/fcb_config_sequencer.md
Name: fcb_config_sequencer

Overview:
Wishbone-master controller that drives the fabric configuration block's register interface to load one bitstream into the eFPGA fabric. It fetches 32-bit words from a valid/ready source (SPI flash reader or CPU FIFO) and programs the length and control registers. It writes each word to the bitstream write register, waits out the serial shift, polls the status register, and cleanly finishes or aborts. It sits between the SoC boot/loader logic and the configuration block.

Parameters:
SHIFT_WAIT, 40, cycles waited after each word write before polling status; must be at least 34.
DONE_TIMEOUT, 1024, maximum poll cycles after the last word before the error is raised.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse that begins a load; ignored while busy
abort  input  1  level; terminates the load at the next cycle
len_bits  input  32  bitstream length in bits; sampled on start
src_data  input  32  next bitstream word
src_valid  input  1  src_data is valid
src_ready  output  1  one-cycle pulse; the word is consumed
wb_address  output  3  configuration block register address
wb_data_out  output  32  write data to the configuration block
wb_data_in  input  32  read data from the configuration block; combinational, valid in the same cycle as stb
wb_select  output  4  byte lanes; always 4'hF when stb is high, else 0
wb_stb  output  1  bus strobe
wb_we  output  1  write enable
wb_bus_cycle  output  1  equals wb_stb
busy  output  1  a load is in progress
done  output  1  one-cycle pulse on successful completion
error  output  1  sticky; cleared by the next accepted start
words_sent  output  32  words written in the current load

Behaviour:
- Reset: all outputs are 0, state is IDLE, counters are 0.
- Bus access rules:
  - Every access is a single-cycle strobe with no ack.
  - Writes assert stb, we, and cyc for exactly one cycle.
  - Reads assert stb and cyc with we=0, and sample wb_data_in in the same cycle.
  - All bus outputs are registered.
- Word count: nwords = ceil(len_bits/32), computed on start as (len_bits+31)>>5 using 33-bit arithmetic.
- IDLE:
  - start with len_bits!=0 → error cleared, busy=1, words_sent=0 → WR_LEN.
  - start with len_bits==0 → error=1, stay IDLE.
- WR_LEN: write addr 2 = len_bits → WR_CTRL.
- WR_CTRL: write addr 0 = 32'h1 → WAIT_SRC.
- WAIT_SRC:
  - When src_valid=1: latch src_data and pulse src_ready for 1 cycle → WR_WORD.
  - Otherwise wait indefinitely.
- WR_WORD: write addr 1 = latched word; words_sent++; wait counter loaded with SHIFT_WAIT → SHIFT.
- SHIFT: count down to 0 → POLL.
- POLL: read addr 4 (status).
  - Status bit1 (bitstream complete) set → CLR_CTRL with success.
  - Else if words_sent < nwords → WAIT_SRC.
  - Else stay in POLL and increment the timeout counter. When it reaches DONE_TIMEOUT → CLR_CTRL with failure.
- CLR_CTRL: write addr 0 = 32'h0; busy → 0.
  - Success: done pulses in this same cycle.
  - Failure: error is set in this same cycle.
  - Next state is IDLE.
- Abort: abort=1 in any non-IDLE state except CLR_CTRL → CLR_CTRL with failure next cycle.
  - An in-flight single-cycle write completes; no second bus access is issued.
- Early completion: status bit1 seen before all words are sent ends the load successfully. Unfetched source words are left untouched.
- Simultaneous events:
  - start while busy is ignored.
  - abort together with status-complete in POLL: abort wins, and error is set.
- reset mid-operation: immediate return to IDLE with all outputs 0. The configuration block itself is reset by its own reset, and no clearing write is issued.
- Counters do not wrap: words_sent is bounded by nwords, and the timeout counter saturates.

Test Plan:
- Normal load: len_bits=96, three words supplied immediately, status bit1 returned on the 3rd poll.
  - Expected bus order: addr2=96, addr0=1, addr1×3, each write followed by 40 idle cycles then a read of addr4.
  - Expected end: addr0=0, done pulses once, words_sent=3, error=0.
- Non-multiple length: len_bits=33 → exactly 2 words fetched; src_ready pulses twice.
- Source stall: src_valid held low 100 cycles before the 2nd word → no bus activity in that window, busy stays 1, and the load then completes normally.
- Timeout: len_bits=64, status bit1 never set → after 2 words plus 1024 polls, addr0=0 is written, error=1, done=0.
- Abort: abort asserted during SHIFT of word 1 → next cycle writes addr0=0, error=1, busy=0; a subsequent start clears error and loads successfully.
- Zero length and mid-op reset:
  - start with len_bits=0 → error=1 and no bus access.
  - reset asserted in POLL → next cycle all outputs are 0 and state is IDLE.
